// File: rtl/wb_stage_mlane_pkg.sv
// Shared definitions for the multi-lane write-back stage: per-lane MEM->WS
// field layout, load-type encodings and the default lane count.
package wb_stage_mlane_pkg;

  localparam int LANES_DEF  = 2;
  localparam int LANE_BUS_W = 109;

  localparam int F_PC       = 0;
  localparam int F_RESULT   = 32;
  localparam int F_DEST     = 64;
  localparam int F_GR_WE    = 69;
  localparam int F_EX       = 70;
  localparam int F_BYTE_OFF = 71;
  localparam int F_RT_VALUE = 73;
  localparam int F_MEM_OP   = 105;
  localparam int F_RES_MEM  = 108;

  typedef enum logic [2:0] {
    OP_LW  = 3'd0,
    OP_LB  = 3'd1,
    OP_LBU = 3'd2,
    OP_LH  = 3'd3,
    OP_LHU = 3'd4,
    OP_LWL = 3'd5,
    OP_LWR = 3'd6,
    OP_RSV = 3'd7
  } mem_op_e;

  typedef struct packed {
    logic        res_from_mem;
    mem_op_e     mem_op;
    logic [31:0] rt_value;
    logic [1:0]  byte_off;
    logic        ex;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] result;
    logic [31:0] pc;
  } lane_t;

endpackage

// File: rtl/wb_stage_mlane_load_align.sv
// Load data alignment and extension for all MIPS load types, including the
// unaligned LWL/LWR merges with the old rt value.
module load_align
  import wb_stage_mlane_pkg::*;
(
  input  mem_op_e     mem_op,
  input  logic [1:0]  byte_off,
  input  logic [31:0] rd,
  input  logic [31:0] rt,
  output logic [31:0] value
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rd[{byte_off, 3'b000} +: 8];
    half_sel = byte_off[1] ? rd[31:16] : rd[15:0];
    case (mem_op)
      OP_LB:  value = {{24{byte_sel[7]}}, byte_sel};
      OP_LBU: value = {24'b0, byte_sel};
      // odd halfword offsets are not legal loads; return zero
      OP_LH:  value = byte_off[0] ? 32'b0 : {{16{half_sel[15]}}, half_sel};
      OP_LHU: value = byte_off[0] ? 32'b0 : {16'b0, half_sel};
      OP_LWL: begin
        case (byte_off)
          2'd0:    value = {rd[7:0],  rt[23:0]};
          2'd1:    value = {rd[15:0], rt[15:0]};
          2'd2:    value = {rd[23:0], rt[7:0]};
          default: value = rd;
        endcase
      end
      OP_LWR: begin
        case (byte_off)
          2'd0:    value = rd;
          2'd1:    value = {rt[31:24], rd[31:8]};
          2'd2:    value = {rt[31:16], rd[31:16]};
          default: value = {rt[31:8],  rd[31:24]};
        endcase
      end
      default: value = rd;
    endcase
  end

endmodule

// File: rtl/wb_stage_mlane.sv
// Multi-lane write-back stage: registers a MEM bundle, waits for the lane 0
// load response and commits every lane in one cycle. Trace ports: WB_TRACE_EN.
module wb_stage_mlane #(
  parameter int LANES      = wb_stage_mlane_pkg::LANES_DEF,
  parameter int DATA_W     = 32,
  parameter int LANE_BUS_W = wb_stage_mlane_pkg::LANE_BUS_W
) (
  input  logic                    clk,
  input  logic                    reset,
  output logic                    ws_allowin,
  input  logic                    ms_to_ws_valid,
  input  logic [LANES*LANE_BUS_W-1:0] ms_to_ws_bus,
  input  logic                    data_ok,
  input  logic [31:0]             data_rdata,
  output logic [LANES-1:0]        rf_we,
  output logic [LANES*5-1:0]      rf_waddr,
  output logic [LANES*DATA_W-1:0] rf_wdata,
  output logic [LANES*5-1:0]      wb_dest,
  output logic [LANES*DATA_W-1:0] wb_result,
  output logic [LANES-1:0]        wb_busy
`ifdef WB_TRACE_EN
  ,
  output logic [LANES*32-1:0]     debug_wb_pc,
  output logic [LANES*4-1:0]      debug_wb_rf_wen,
  output logic [LANES*5-1:0]      debug_wb_rf_wnum,
  output logic [LANES*32-1:0]     debug_wb_rf_wdata
`endif
);
  import wb_stage_mlane_pkg::*;

  logic                        ws_valid;
  logic [LANES*LANE_BUS_W-1:0] bus_r;
  logic [31:0]                 ld_buf;
  logic                        ld_got;
  lane_t                       lane [LANES];
  logic                        ld_need;
  logic                        ws_ready_go;
  logic                        commit;
  logic [31:0]                 ld_raw;
  logic [31:0]                 ld_aligned;
  logic [LANES-1:0]            lane_wr;
  logic [LANES-1:0]            lane_shadow;
  logic                        unused_fields;

  always_comb begin
    for (int i = 0; i < LANES; i++) lane[i] = lane_t'(bus_r[i*LANE_BUS_W +: LANE_BUS_W]);
  end

  assign ld_need     = ws_valid & lane[0].res_from_mem & ~lane[0].ex;
  assign ws_ready_go = ~ld_need | ld_got | data_ok;
  assign ws_allowin  = ~ws_valid | ws_ready_go;
  assign commit      = ws_valid & ws_ready_go;
  assign ld_raw      = data_ok ? data_rdata : ld_buf;

  always_ff @(posedge clk) begin
    if (reset) begin
      ws_valid <= 1'b0;
      bus_r    <= '0;
      ld_buf   <= '0;
      ld_got   <= 1'b0;
    end else begin
      if (ws_allowin) ws_valid <= ms_to_ws_valid;
      if (ms_to_ws_valid & ws_allowin) begin
        bus_r  <= ms_to_ws_bus;
        ld_got <= 1'b0;
      end else if (data_ok & ld_need) begin
        ld_got <= 1'b1;
      end
      if (data_ok & ld_need) ld_buf <= data_rdata;
    end
  end

  load_align u_load_align (
    .mem_op   (lane[0].mem_op),
    .byte_off (lane[0].byte_off),
    .rd       (ld_raw),
    .rt       (lane[0].rt_value),
    .value    (ld_aligned)
  );

  // a lane is shadowed when a younger lane writes the same nonzero register
  always_comb begin
    lane_wr     = '0;
    lane_shadow = '0;
    for (int i = 0; i < LANES; i++) lane_wr[i] = lane[i].gr_we & ~lane[i].ex;
    for (int i = 0; i < LANES; i++)
      for (int j = i + 1; j < LANES; j++)
        if (lane_wr[j] && (lane[j].dest == lane[i].dest) && (lane[i].dest != 5'd0))
          lane_shadow[i] = 1'b1;
  end

  always_comb begin
    logic [31:0] lane_res;
    rf_we     = '0;
    rf_waddr  = '0;
    rf_wdata  = '0;
    wb_dest   = '0;
    wb_result = '0;
    wb_busy   = '0;
    lane_res  = '0;
    for (int i = 0; i < LANES; i++) begin
      lane_res = ((i == 0) && lane[i].res_from_mem) ? ld_aligned : lane[i].result;
      rf_we[i]                    = commit & lane_wr[i] & ~lane_shadow[i];
      rf_waddr[i*5 +: 5]          = lane[i].dest;
      rf_wdata[i*DATA_W +: DATA_W] = lane_res;
      wb_dest[i*5 +: 5]           = (ws_valid & lane_wr[i]) ? lane[i].dest : 5'd0;
      wb_result[i*DATA_W +: DATA_W] = lane_res;
    end
    wb_busy[0] = ld_need & ~ld_got & ~data_ok;
  end

  // fields that only lane 0 or the trace path consume
  always_comb begin
    unused_fields = 1'b0;
    for (int i = 0; i < LANES; i++) unused_fields = unused_fields ^ (^lane[i].pc);
    for (int i = 1; i < LANES; i++)
      unused_fields = unused_fields ^ lane[i].res_from_mem ^ (^lane[i].mem_op)
                    ^ (^lane[i].rt_value) ^ (^lane[i].byte_off);
  end

`ifdef WB_TRACE_EN
  always_comb begin
    debug_wb_pc       = '0;
    debug_wb_rf_wen   = '0;
    debug_wb_rf_wnum  = '0;
    debug_wb_rf_wdata = '0;
    for (int i = 0; i < LANES; i++) begin
      debug_wb_pc[i*32 +: 32]       = lane[i].pc;
      debug_wb_rf_wen[i*4 +: 4]     = {4{rf_we[i]}};
      debug_wb_rf_wnum[i*5 +: 5]    = rf_waddr[i*5 +: 5];
      debug_wb_rf_wdata[i*32 +: 32] = rf_wdata[i*DATA_W +: 32];
    end
  end
`endif

endmodule

// File: tb/tb_wb_stage_mlane.sv
// Scoreboard bench for wb_stage_mlane (two lanes): stimulus queues expected
// commits, a negedge monitor compares them whenever the stage commits.
module tb_wb_stage_mlane;

  localparam int LANES = 2;
  localparam int LBW   = 109;

  typedef struct {
    logic [1:0]  we;
    logic [9:0]  waddr;
    logic [63:0] wdata;
  } exp_t;

  logic                  clk = 1'b0;
  logic                  reset = 1'b1;
  logic                  ws_allowin;
  logic                  ms_to_ws_valid = 1'b0;
  logic [LANES*LBW-1:0]  ms_to_ws_bus = '0;
  logic                  data_ok = 1'b0;
  logic [31:0]           data_rdata = '0;
  logic [LANES-1:0]      rf_we;
  logic [LANES*5-1:0]    rf_waddr;
  logic [LANES*32-1:0]   rf_wdata;
  logic [LANES*5-1:0]    wb_dest;
  logic [LANES*32-1:0]   wb_result;
  logic [LANES-1:0]      wb_busy;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t exp_q[$];

  wb_stage_mlane #(.LANES(LANES), .DATA_W(32), .LANE_BUS_W(LBW)) dut (
    .clk            (clk),
    .reset          (reset),
    .ws_allowin     (ws_allowin),
    .ms_to_ws_valid (ms_to_ws_valid),
    .ms_to_ws_bus   (ms_to_ws_bus),
    .data_ok        (data_ok),
    .data_rdata     (data_rdata),
    .rf_we          (rf_we),
    .rf_waddr       (rf_waddr),
    .rf_wdata       (rf_wdata),
    .wb_dest        (wb_dest),
    .wb_result      (wb_result),
    .wb_busy        (wb_busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required finish before 200000");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, expv);
    end
  endtask

  function automatic logic [LBW-1:0] mk(input logic rfm, input logic [2:0] op,
                                        input logic [31:0] rt, input logic [1:0] off,
                                        input logic ex, input logic we, input logic [4:0] dest,
                                        input logic [31:0] res, input logic [31:0] pc);
    return {rfm, op, rt, off, ex, we, dest, res, pc};
  endfunction

  task automatic push_exp(input logic [1:0] we, input logic [4:0] a1, input logic [4:0] a0,
                          input logic [31:0] d1, input logic [31:0] d0);
    exp_t e;
    e.we    = we;
    e.waddr = {a1, a0};
    e.wdata = {d1, d0};
    exp_q.push_back(e);
  endtask

  // drive a bundle until the stage accepts it; called just after a posedge
  task automatic issue(input logic [LBW-1:0] l1, input logic [LBW-1:0] l0);
    int n;
    n = 0;
    ms_to_ws_valid = 1'b1;
    ms_to_ws_bus   = {l1, l0};
    @(negedge clk);
    while (!ws_allowin && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!ws_allowin) begin
      n_checks++;
      n_fail++;
      $display("FAIL issue_wait: ws_allowin stayed 0, required 1 within 20 cycles");
    end
    @(posedge clk);
    #1;
    ms_to_ws_valid = 1'b0;
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (!reset && dut.ws_valid && ws_allowin) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_commit: rf_we 0x%0h with no commit expected", rf_we);
      end else begin
        exp_t e;
        logic [9:0]  amask;
        logic [63:0] dmask;
        e     = exp_q.pop_front();
        amask = {{5{e.we[1]}}, {5{e.we[0]}}};
        dmask = {{32{e.we[1]}}, {32{e.we[0]}}};
        chk("commit_rf_we", 64'(rf_we), 64'(e.we));
        chk("commit_rf_waddr", 64'(rf_waddr & amask), 64'(e.waddr & amask));
        chk("commit_rf_wdata", rf_wdata & dmask, e.wdata & dmask);
      end
    end
  end

  typedef struct {
    logic [2:0]  op;
    logic [1:0]  off;
    logic [31:0] rt;
    logic [31:0] rd;
    logic [31:0] res;
  } ldvec_t;

  ldvec_t ld_tab[$];

  initial begin
    ld_tab = '{
      '{3'd6, 2'd1, 32'hAABB_CCDD, 32'h1122_3344, 32'hAA11_2233},
      '{3'd5, 2'd2, 32'hAABB_CCDD, 32'h1122_3344, 32'h2233_44DD},
      '{3'd5, 2'd0, 32'hAABB_CCDD, 32'h1122_3344, 32'h44BB_CCDD},
      '{3'd6, 2'd3, 32'hAABB_CCDD, 32'h1122_3344, 32'hAABB_CC11},
      '{3'd2, 2'd2, 32'h0,         32'h0080_0000, 32'h0000_0080},
      '{3'd3, 2'd2, 32'h0,         32'h8001_1234, 32'hFFFF_8001},
      '{3'd4, 2'd0, 32'h0,         32'h8001_1234, 32'h0000_1234},
      '{3'd3, 2'd1, 32'h0,         32'h8001_1234, 32'h0000_0000},
      '{3'd0, 2'd0, 32'h0,         32'h1234_5678, 32'h1234_5678},
      '{3'd7, 2'd0, 32'h0,         32'hCAFE_F00D, 32'hCAFE_F00D}
    };

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_rf_we", 64'(rf_we), 64'd0);
    chk("reset_wb_dest", 64'(wb_dest), 64'd0);
    chk("reset_wb_busy", 64'(wb_busy), 64'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("idle_allowin", 64'(ws_allowin), 64'd1);
    @(posedge clk);
    #1;

    // two ADDU bundles back to back
    push_exp(2'b11, 5'd4, 5'd3, 32'h22, 32'h11);
    issue(mk(0, 0, 0, 0, 0, 1, 5'd4, 32'h22, 32'h104), mk(0, 0, 0, 0, 0, 1, 5'd3, 32'h11, 32'h100));
    push_exp(2'b11, 5'd7, 5'd6, 32'h77, 32'h66);
    ms_to_ws_valid = 1'b1;
    ms_to_ws_bus   = {mk(0, 0, 0, 0, 0, 1, 5'd7, 32'h77, 32'h10C), mk(0, 0, 0, 0, 0, 1, 5'd6, 32'h66, 32'h108)};
    @(negedge clk);
    chk("b2b_allowin", 64'(ws_allowin), 64'd1);
    @(posedge clk);
    #1 ms_to_ws_valid = 1'b0;
    @(negedge clk);
    chk("b2b_allowin_2", 64'(ws_allowin), 64'd1);
    @(posedge clk);
    #1;

    // LB stalled for three cycles
    push_exp(2'b11, 5'd9, 5'd8, 32'h99, 32'hFFFF_FF80);
    issue(mk(0, 0, 0, 0, 0, 1, 5'd9, 32'h99, 32'h204), mk(1, 3'd1, 32'h0, 2'd2, 0, 1, 5'd8, 32'h0, 32'h200));
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("stall_wb_busy", 64'(wb_busy), 64'b01);
      chk("stall_allowin", 64'(ws_allowin), 64'd0);
    end
    chk("stall_wb_dest", 64'(wb_dest), {54'd0, 5'd9, 5'd8});
    @(posedge clk);
    #1 data_ok = 1'b1;
    data_rdata = 32'h0080_0000;
    @(negedge clk);
    chk("dataok_wb_busy", 64'(wb_busy), 64'd0);
    @(posedge clk);
    #1 data_ok = 1'b0;

    // alignment table, data in the first WS cycle
    foreach (ld_tab[t]) begin
      push_exp(2'b01, 5'd0, 5'd10, 32'h0, ld_tab[t].res);
      issue(mk(0, 0, 0, 0, 0, 0, 5'd0, 32'h0, 32'h0),
            mk(1, ld_tab[t].op, ld_tab[t].rt, ld_tab[t].off, 0, 1, 5'd10, 32'hDEAD, 32'h300));
      data_ok    = 1'b1;
      data_rdata = ld_tab[t].rd;
      @(posedge clk);
      #1 data_ok = 1'b0;
    end

    // same destination on both lanes: youngest wins
    push_exp(2'b10, 5'd5, 5'd0, 32'hAA, 32'h0);
    issue(mk(0, 0, 0, 0, 0, 1, 5'd5, 32'hAA, 32'h404), mk(0, 0, 0, 0, 0, 1, 5'd5, 32'h55, 32'h400));

    // excepting load on lane 0 neither stalls nor writes
    push_exp(2'b10, 5'd12, 5'd0, 32'h0C, 32'h0);
    issue(mk(0, 0, 0, 0, 0, 1, 5'd12, 32'h0C, 32'h504), mk(1, 3'd0, 0, 0, 1, 1, 5'd11, 32'h0, 32'h500));
    @(negedge clk);
    chk("ex_allowin", 64'(ws_allowin), 64'd1);
    chk("ex_wb_busy", 64'(wb_busy), 64'd0);
    @(posedge clk);
    #1;

    // reset during a load stall drops the bundle
    issue(mk(0, 0, 0, 0, 0, 0, 5'd0, 32'h0, 32'h0), mk(1, 3'd0, 0, 0, 0, 1, 5'd13, 32'h0, 32'h600));
    @(negedge clk);
    chk("pre_reset_busy", 64'(wb_busy), 64'b01);
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    data_ok    = 1'b1;
    data_rdata = 32'h0000_0555;
    @(negedge clk);
    chk("post_reset_rf_we", 64'(rf_we), 64'd0);
    chk("post_reset_allowin", 64'(ws_allowin), 64'd1);
    chk("post_reset_busy", 64'(wb_busy), 64'd0);
    @(posedge clk);
    #1 data_ok = 1'b0;

    repeat (3) @(posedge clk);
    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
